// File: rtl/avmm_router_pkg.sv
// Shared types and sizing helpers for the Avalon-MM DDR bank router.
package avmm_router_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WR_BURST = 1'b1
   } wr_state_e;

   localparam int DEF_BURST_W = 3;
   localparam int MAX_BURST   = 2 ** (DEF_BURST_W - 1);

   // A single bank needs no select bits at all.
   function automatic int bank_idx_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 0;
   endfunction

   function automatic int max_burst(input int burst_w);
      return 2 ** (burst_w - 1);
   endfunction

endpackage

// File: rtl/avmm_rd_credit_tracker.sv
// Read-side bookkeeping: outstanding beat count, owning bank, read admission and stray-return flag.
// Returns from the owning bank are passed on as ret_vld_o; anything else is dropped and flagged.
module avmm_rd_credit_tracker
   import avmm_router_pkg::*;
#(
   parameter int NUM_BANKS    = 4,
   parameter int BURST_W      = 3,
   parameter int MAX_RD_BEATS = 32,
   parameter int SEL_W        = 2,
   parameter int CNT_W        = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SEL_W-1:0]     sel_i,
   input  logic [BURST_W-1:0]   burst_i,
   input  logic                 rd_acc_i,
   input  logic [NUM_BANKS-1:0] rdv_i,
   output logic                 allowed_o,
   output logic [SEL_W-1:0]     rd_bank_o,
   output logic                 ret_vld_o,
   output logic [CNT_W-1:0]     cnt_o,
   output logic                 err_o
);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]     rd_bank_q, rd_bank_d;
   logic                 err_q, err_d;
   logic [NUM_BANKS-1:0] bank_mask;
   logic [CNT_W:0]       cnt_sum;
   logic                 own_rdv;
   logic                 stray;

   assign bank_mask = NUM_BANKS'(1) << rd_bank_q;
   assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(burst_i);
   assign own_rdv   = |(rdv_i & bank_mask);

   // Reads may only chain onto the bank already owning the return stream.
   assign allowed_o = ((cnt_q == '0) || (sel_i == rd_bank_q)) &&
                      (cnt_sum <= (CNT_W+1)'(MAX_RD_BEATS));

   assign ret_vld_o = own_rdv && (cnt_q != '0);
   assign stray     = (|(rdv_i & ~bank_mask)) || (own_rdv && (cnt_q == '0));

   always_comb begin
      cnt_d     = cnt_q;
      rd_bank_d = rd_bank_q;
      err_d     = err_q | stray;
      if (rd_acc_i) begin
         cnt_d     = cnt_d + CNT_W'(burst_i);
         rd_bank_d = sel_i;
      end
      if (ret_vld_o) begin
         cnt_d = cnt_d - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         rd_bank_q <= '0;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rd_bank_q <= rd_bank_d;
         err_q     <= err_d;
      end
   end

   assign rd_bank_o = rd_bank_q;
   assign cnt_o     = cnt_q;
   assign err_o     = err_q;

endmodule

// File: rtl/avmm_ddr_bank_router.sv
// Address-decodes one Avalon-MM burst slave onto NUM_BANKS bank masters; zero-latency commands,
// one-cycle registered read return, write bursts pinned to their first bank.
module avmm_ddr_bank_router
   import avmm_router_pkg::*;
#(
   parameter int NUM_BANKS    = 4,
   parameter int DATA_W       = 512,
   parameter int BANK_ADDR_W  = 32,
   parameter int BURST_W      = 3,
   parameter int MAX_RD_BEATS = 32,
   localparam int BANK_W      = bank_idx_w(NUM_BANKS),
   localparam int CNT_W       = $clog2(MAX_RD_BEATS) + 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [BANK_ADDR_W+BANK_W-1:0]     s_address,
   input  logic                              s_read,
   input  logic                              s_write,
   input  logic [BURST_W-1:0]                s_burstcount,
   input  logic [DATA_W-1:0]                 s_writedata,
   input  logic [DATA_W/8-1:0]               s_byteenable,
   output logic                              s_waitrequest,
   output logic [DATA_W-1:0]                 s_readdata,
   output logic                              s_readdatavalid,
   output logic [NUM_BANKS*BANK_ADDR_W-1:0]  m_address,
   output logic [NUM_BANKS-1:0]              m_read,
   output logic [NUM_BANKS-1:0]              m_write,
   output logic [NUM_BANKS*BURST_W-1:0]      m_burstcount,
   output logic [NUM_BANKS*DATA_W-1:0]       m_writedata,
   output logic [NUM_BANKS*(DATA_W/8)-1:0]   m_byteenable,
   input  logic [NUM_BANKS-1:0]              m_waitrequest,
   input  logic [NUM_BANKS*DATA_W-1:0]       m_readdata,
   input  logic [NUM_BANKS-1:0]              m_readdatavalid,
   output logic                              err_stray_rdv,
   output logic [CNT_W-1:0]                  rd_beats_outstanding
);

   localparam int SEL_W = (BANK_W > 0) ? BANK_W : 1;

   wr_state_e            state_q, state_d;
   logic [BURST_W-1:0]   beats_left_q, beats_left_d;
   logic [SEL_W-1:0]     wr_bank_q, wr_bank_d;
   logic [SEL_W-1:0]     addr_bank;
   logic [SEL_W-1:0]     sel;
   logic [NUM_BANKS-1:0] sel_mask;
   logic                 rd_allowed;
   logic                 rd_ok;
   logic                 rd_acc;
   logic                 wr_acc;
   logic [SEL_W-1:0]     rd_bank;
   logic                 ret_vld;
   logic                 rdv_q;
   logic [DATA_W-1:0]    rdata_q;

   if (BANK_W > 0) begin : g_decode
      assign addr_bank = s_address[BANK_ADDR_W +: SEL_W];
   end else begin : g_single
      assign addr_bank = '0;
   end

   assign sel      = (state_q == WR_BURST) ? wr_bank_q : addr_bank;
   assign sel_mask = NUM_BANKS'(1) << sel;

   // Reads never interleave into an open write burst.
   assign rd_ok         = rd_allowed && (state_q == IDLE);
   assign s_waitrequest = reset | m_waitrequest[sel] | (s_read & ~rd_ok);
   assign rd_acc        = s_read & ~s_waitrequest;
   assign wr_acc        = s_write & ~s_waitrequest;

   assign m_read       = (s_read && rd_ok && !reset) ? sel_mask : '0;
   assign m_write      = (s_write && !reset) ? sel_mask : '0;
   assign m_address    = {NUM_BANKS{s_address[BANK_ADDR_W-1:0]}};
   assign m_burstcount = {NUM_BANKS{s_burstcount}};
   assign m_writedata  = {NUM_BANKS{s_writedata}};
   assign m_byteenable = {NUM_BANKS{s_byteenable}};

   always_comb begin
      state_d      = state_q;
      beats_left_d = beats_left_q;
      wr_bank_d    = wr_bank_q;
      case (state_q)
         IDLE: begin
            if (wr_acc && (s_burstcount > BURST_W'(1))) begin
               state_d      = WR_BURST;
               beats_left_d = s_burstcount - BURST_W'(1);
               wr_bank_d    = addr_bank;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               beats_left_d = beats_left_q - BURST_W'(1);
               if (beats_left_q == BURST_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         beats_left_q <= '0;
         wr_bank_q    <= '0;
      end else begin
         state_q      <= state_d;
         beats_left_q <= beats_left_d;
         wr_bank_q    <= wr_bank_d;
      end
   end

   avmm_rd_credit_tracker #(
      .NUM_BANKS    (NUM_BANKS),
      .BURST_W      (BURST_W),
      .MAX_RD_BEATS (MAX_RD_BEATS),
      .SEL_W        (SEL_W),
      .CNT_W        (CNT_W)
   ) u_rd_credit (
      .clk       (clk),
      .reset     (reset),
      .sel_i     (sel),
      .burst_i   (s_burstcount),
      .rd_acc_i  (rd_acc),
      .rdv_i     (m_readdatavalid),
      .allowed_o (rd_allowed),
      .rd_bank_o (rd_bank),
      .ret_vld_o (ret_vld),
      .cnt_o     (rd_beats_outstanding),
      .err_o     (err_stray_rdv)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rdv_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         rdv_q <= ret_vld;
         if (ret_vld) begin
            rdata_q <= m_readdata[rd_bank*DATA_W +: DATA_W];
         end
      end
   end

   assign s_readdatavalid = rdv_q;
   assign s_readdata      = rdata_q;

endmodule

// File: tb/tb_avmm_ddr_bank_router.sv
// Directed bench for avmm_ddr_bank_router: 4 banks, 32-bit data, 8-beat read budget.
module tb_avmm_ddr_bank_router;

   localparam int NB = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = 3;
   localparam int MR = 8;
   localparam int CW = $clog2(MR) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [AW+1:0]     s_address;
   logic              s_read, s_write;
   logic [BW-1:0]     s_burstcount;
   logic [DW-1:0]     s_writedata;
   logic [DW/8-1:0]   s_byteenable;
   logic              s_waitrequest;
   logic [DW-1:0]     s_readdata;
   logic              s_readdatavalid;
   logic [NB*AW-1:0]  m_address;
   logic [NB-1:0]     m_read, m_write;
   logic [NB*BW-1:0]  m_burstcount;
   logic [NB*DW-1:0]  m_writedata;
   logic [NB*(DW/8)-1:0] m_byteenable;
   logic [NB-1:0]     m_waitrequest;
   logic [NB*DW-1:0]  m_readdata;
   logic [NB-1:0]     m_readdatavalid;
   logic              err_stray_rdv;
   logic [CW-1:0]     rd_beats_outstanding;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   avmm_ddr_bank_router #(
      .NUM_BANKS(NB), .DATA_W(DW), .BANK_ADDR_W(AW), .BURST_W(BW), .MAX_RD_BEATS(MR)
   ) dut (
      .clk(clk), .reset(reset),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .err_stray_rdv(err_stray_rdv), .rd_beats_outstanding(rd_beats_outstanding)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      s_read = 1'b0;
      s_write = 1'b0;
      m_readdatavalid = '0;
      m_waitrequest = '0;
   endtask

   task automatic test_reset();
      quiet();
      reset = 1'b1;
      s_write = 1'b1;
      s_address = {2'd1, 32'h40};
      s_burstcount = 3'd1;
      nxt();
      nxt();
      #1;
      checks++; if (s_waitrequest !== 1'b1) begin errs++; $display("FAIL reset_waitreq got=%b exp=1", s_waitrequest); end
      checks++; if (m_write !== 4'b0000) begin errs++; $display("FAIL reset_m_write got=%b exp=0000", m_write); end
      checks++; if (m_read !== 4'b0000) begin errs++; $display("FAIL reset_m_read got=%b exp=0000", m_read); end
      checks++; if (s_readdatavalid !== 1'b0) begin errs++; $display("FAIL reset_rdv got=%b exp=0", s_readdatavalid); end
      checks++; if (err_stray_rdv !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err_stray_rdv); end
      checks++; if (rd_beats_outstanding !== 4'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", rd_beats_outstanding); end
      quiet();
      reset = 1'b0;
      nxt();
   endtask

   task automatic test_single_writes();
      for (int b = 0; b < NB; b++) begin
         logic [NB-1:0] exp_w;
         exp_w = 4'(1 << b);
         s_write = 1'b1;
         s_address = {2'(b), 32'h40};
         s_burstcount = 3'd1;
         s_writedata = 32'hD000_0000 + 32'(b);
         s_byteenable = 4'hA;
         #1;
         checks++; if (m_write !== exp_w) begin errs++; $display("FAIL single_wr_sel bank=%0d got=%b exp=%b", b, m_write, exp_w); end
         checks++; if (m_address[b*AW +: AW] !== 32'h40) begin errs++; $display("FAIL single_wr_addr bank=%0d got=%h exp=40", b, m_address[b*AW +: AW]); end
         checks++; if (m_writedata[b*DW +: DW] !== 32'hD000_0000 + 32'(b)) begin errs++; $display("FAIL single_wr_data bank=%0d got=%h", b, m_writedata[b*DW +: DW]); end
         checks++; if (m_byteenable[b*4 +: 4] !== 4'hA) begin errs++; $display("FAIL single_wr_be bank=%0d got=%h exp=a", b, m_byteenable[b*4 +: 4]); end
         checks++; if (s_waitrequest !== 1'b0) begin errs++; $display("FAIL single_wr_wait bank=%0d got=%b exp=0", b, s_waitrequest); end
         nxt();
      end
      quiet();
   endtask

   task automatic test_write_burst();
      s_write = 1'b1;
      s_address = {2'd1, 32'h100};
      s_burstcount = 3'd4;
      #1;
      checks++; if (m_write !== 4'b0010) begin errs++; $display("FAIL burst_beat1 got=%b exp=0010", m_write); end
      nxt();
      s_write = 1'b0;
      s_read = 1'b1;
      s_address = {2'd0, 32'h0};
      s_burstcount = 3'd1;
      #1;
      checks++; if (s_waitrequest !== 1'b1) begin errs++; $display("FAIL burst_rd_hold_wait got=%b exp=1", s_waitrequest); end
      checks++; if (m_read !== 4'b0000) begin errs++; $display("FAIL burst_rd_hold_mread got=%b exp=0000", m_read); end
      nxt();
      s_read = 1'b0;
      s_write = 1'b1;
      s_address = {2'd2, 32'h140};
      s_burstcount = 3'd4;
      for (int i = 2; i <= 4; i++) begin
         if (i == 3) begin
            m_waitrequest = 4'b0010;
            #1;
            checks++; if (s_waitrequest !== 1'b1) begin errs++; $display("FAIL burst_stall got=%b exp=1", s_waitrequest); end
            nxt();
            m_waitrequest = '0;
         end
         #1;
         checks++; if (m_write !== 4'b0010) begin errs++; $display("FAIL burst_beat%0d got=%b exp=0010", i, m_write); end
         nxt();
      end
      s_address = {2'd2, 32'h180};
      s_burstcount = 3'd1;
      #1;
      checks++; if (m_write !== 4'b0100) begin errs++; $display("FAIL burst_back_idle got=%b exp=0100", m_write); end
      nxt();
      quiet();
   endtask

   task automatic test_read_order();
      s_read = 1'b1;
      s_address = {2'd0, 32'h200};
      s_burstcount = 3'd4;
      #1;
      checks++; if (m_read !== 4'b0001) begin errs++; $display("FAIL rd0_issue got=%b exp=0001", m_read); end
      checks++; if (s_waitrequest !== 1'b0) begin errs++; $display("FAIL rd0_wait got=%b exp=0", s_waitrequest); end
      nxt();
      checks++; if (rd_beats_outstanding !== 4'd4) begin errs++; $display("FAIL rd0_cnt got=%0d exp=4", rd_beats_outstanding); end
      s_address = {2'd3, 32'h300};
      s_burstcount = 3'd1;
      m_readdata = '0;
      m_readdata[127:96] = 32'hDEAD;
      for (int k = 0; k < 4; k++) begin
         m_readdatavalid = 4'b0001;
         m_readdata[31:0] = 32'hA0 + 32'(k);
         #1;
         checks++; if (s_waitrequest !== 1'b1 || m_read !== 4'b0000) begin errs++; $display("FAIL rd3_blocked k=%0d wait=%b mread=%b exp=1/0000", k, s_waitrequest, m_read); end
         if (k == 0) begin
            checks++; if (s_readdatavalid !== 1'b0) begin errs++; $display("FAIL rd0_no_early_rdv got=%b exp=0", s_readdatavalid); end
         end else begin
            checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hA0 + 32'(k - 1)) begin errs++; $display("FAIL rd0_return k=%0d vld=%b data=%h exp=1/%h", k, s_readdatavalid, s_readdata, 32'hA0 + 32'(k - 1)); end
         end
         nxt();
      end
      m_readdatavalid = '0;
      #1;
      checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hA3) begin errs++; $display("FAIL rd0_last vld=%b data=%h exp=1/a3", s_readdatavalid, s_readdata); end
      checks++; if (m_read !== 4'b1000 || s_waitrequest !== 1'b0) begin errs++; $display("FAIL rd3_issue mread=%b wait=%b exp=1000/0", m_read, s_waitrequest); end
      nxt();
      s_read = 1'b0;
      m_readdatavalid = 4'b1000;
      m_readdata[127:96] = 32'hB0;
      #1;
      checks++; if (rd_beats_outstanding !== 4'd1) begin errs++; $display("FAIL rd3_cnt got=%0d exp=1", rd_beats_outstanding); end
      nxt();
      m_readdatavalid = '0;
      #1;
      checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hB0) begin errs++; $display("FAIL rd3_return vld=%b data=%h exp=1/b0", s_readdatavalid, s_readdata); end
      checks++; if (rd_beats_outstanding !== 4'd0) begin errs++; $display("FAIL rd3_drained got=%0d exp=0", rd_beats_outstanding); end
      checks++; if (err_stray_rdv !== 1'b0) begin errs++; $display("FAIL rd_no_err got=%b exp=0", err_stray_rdv); end
      nxt();
      quiet();
   endtask

   task automatic test_credit_limit();
      s_read = 1'b1;
      s_address = {2'd2, 32'h400};
      s_burstcount = 3'd4;
      #1;
      checks++; if (s_waitrequest !== 1'b0) begin errs++; $display("FAIL credit_first got=%b exp=0", s_waitrequest); end
      nxt();
      #1;
      checks++; if (s_waitrequest !== 1'b0) begin errs++; $display("FAIL credit_second got=%b exp=0", s_waitrequest); end
      nxt();
      checks++; if (rd_beats_outstanding !== 4'd8) begin errs++; $display("FAIL credit_full got=%0d exp=8", rd_beats_outstanding); end
      s_burstcount = 3'd1;
      #1;
      checks++; if (s_waitrequest !== 1'b1 || m_read !== 4'b0000) begin errs++; $display("FAIL credit_stall wait=%b mread=%b exp=1/0000", s_waitrequest, m_read); end
      nxt();
      m_readdatavalid = 4'b0100;
      #1;
      checks++; if (s_waitrequest !== 1'b1) begin errs++; $display("FAIL credit_stall_ret got=%b exp=1", s_waitrequest); end
      nxt();
      m_readdatavalid = '0;
      #1;
      checks++; if (rd_beats_outstanding !== 4'd7) begin errs++; $display("FAIL credit_after_ret got=%0d exp=7", rd_beats_outstanding); end
      checks++; if (s_waitrequest !== 1'b0 || m_read !== 4'b0100) begin errs++; $display("FAIL credit_release wait=%b mread=%b exp=0/0100", s_waitrequest, m_read); end
      nxt();
      s_read = 1'b0;
      #1;
      checks++; if (rd_beats_outstanding !== 4'd8) begin errs++; $display("FAIL credit_refill got=%0d exp=8", rd_beats_outstanding); end
      m_readdatavalid = 4'b0100;
      repeat (8) nxt();
      m_readdatavalid = '0;
      #1;
      checks++; if (rd_beats_outstanding !== 4'd0 || err_stray_rdv !== 1'b0) begin errs++; $display("FAIL credit_drain cnt=%0d err=%b exp=0/0", rd_beats_outstanding, err_stray_rdv); end
      nxt();
   endtask

   task automatic test_stray();
      m_readdatavalid = 4'b1000;
      nxt();
      m_readdatavalid = '0;
      #1;
      checks++; if (err_stray_rdv !== 1'b1) begin errs++; $display("FAIL stray_set got=%b exp=1", err_stray_rdv); end
      checks++; if (s_readdatavalid !== 1'b0) begin errs++; $display("FAIL stray_dropped got=%b exp=0", s_readdatavalid); end
      checks++; if (rd_beats_outstanding !== 4'd0) begin errs++; $display("FAIL stray_cnt got=%0d exp=0", rd_beats_outstanding); end
      repeat (3) nxt();
      checks++; if (err_stray_rdv !== 1'b1) begin errs++; $display("FAIL stray_sticky got=%b exp=1", err_stray_rdv); end
   endtask

   task automatic test_reset_mid_burst();
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      #1;
      checks++; if (err_stray_rdv !== 1'b0) begin errs++; $display("FAIL rst_clears_err got=%b exp=0", err_stray_rdv); end
      s_read = 1'b1;
      s_address = {2'd1, 32'h500};
      s_burstcount = 3'd4;
      nxt();
      s_burstcount = 3'd2;
      nxt();
      s_read = 1'b0;
      #1;
      checks++; if (rd_beats_outstanding !== 4'd6) begin errs++; $display("FAIL rst_setup_cnt got=%0d exp=6", rd_beats_outstanding); end
      s_write = 1'b1;
      s_address = {2'd0, 32'h540};
      s_burstcount = 3'd4;
      nxt();
      nxt();
      reset = 1'b1;
      s_address = {2'd2, 32'h580};
      #1;
      checks++; if (s_waitrequest !== 1'b1 || m_write !== 4'b0000) begin errs++; $display("FAIL rst_mid_out wait=%b mwrite=%b exp=1/0000", s_waitrequest, m_write); end
      nxt();
      checks++; if (rd_beats_outstanding !== 4'd0) begin errs++; $display("FAIL rst_mid_cnt got=%0d exp=0", rd_beats_outstanding); end
      checks++; if (s_waitrequest !== 1'b1) begin errs++; $display("FAIL rst_mid_hold got=%b exp=1", s_waitrequest); end
      nxt();
      reset = 1'b0;
      s_address = {2'd2, 32'h600};
      s_burstcount = 3'd1;
      #1;
      checks++; if (m_write !== 4'b0100 || s_waitrequest !== 1'b0) begin errs++; $display("FAIL rst_idle_decode mwrite=%b wait=%b exp=0100/0", m_write, s_waitrequest); end
      nxt();
      quiet();
      m_readdatavalid = 4'b0010;
      nxt();
      m_readdatavalid = '0;
      #1;
      checks++; if (err_stray_rdv !== 1'b1 || s_readdatavalid !== 1'b0) begin errs++; $display("FAIL rst_late_return err=%b vld=%b exp=1/0", err_stray_rdv, s_readdatavalid); end
   endtask

   initial begin
      reset = 1'b1;
      s_address = '0;
      s_burstcount = 3'd1;
      s_writedata = '0;
      s_byteenable = '1;
      m_readdata = '0;
      quiet();
      test_reset();
      test_single_writes();
      test_write_burst();
      test_read_order();
      test_credit_limit();
      test_stray();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
